bcd_score_counter: RTL and testbench

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

---
 rtl/score_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/bcd_score_counter.sv | 137 +++++++++++++
 tb/tb_bcd_score_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
// Digit typedef, FSM states, display glyph constants.
package score_pkg;

  typedef enum logic {
    Idle,
    Count
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam bcd_t       BCD_NINE  = 4'd9;

  // Next BCD value of one digit, 9 rolls to 0.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == BCD_NINE) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment glyph {g,f,e,d,c,b,a}.
// Non-BCD codes decode to a blank digit.
module seg7_decode
  import score_pkg::*;
(
  input  bcd_t       i_digit,
  output logic [6:0] o_seg
);

  // Standard glyph table.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_score_counter.sv
// BCD game score counter with best-score memory.
// Idle/Count FSM, saturating or wrapping count, 7-seg display.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SATURATE   = 1,
  parameter int BLANK_LZ   = 0
)(
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       inc,
  input  logic                       clear,
  input  logic                       show_best,
  output logic [NUM_DIGITS-1:0][6:0] HEX,
  output logic                       at_max,
  output logic                       wrapped,
  output logic                       new_best
);

  localparam int ND       = NUM_DIGITS;
  localparam bit LP_SAT   = (SATURATE != 0);
  localparam bit LP_BLANK = (BLANK_LZ != 0);

  state_t r_state;
  state_t w_state_nxt;

  bcd_t r_cur  [ND];
  bcd_t r_best [ND];
  bcd_t w_nxt  [ND];
  bcd_t w_sel  [ND];

  logic [6:0] w_glyph [ND];

  logic [ND-1:0] w_is9;
  logic [ND-1:0] w_carry;
  logic [ND-1:0] w_eq;
  logic [ND-1:0] w_win;
  logic [ND-1:0] w_nz;
  logic [ND-1:0] w_blank;

  logic w_all9;
  logic w_hold;
  logic w_step;
  logic w_gt;
  logic w_dash;
  logic r_wrapped;
  logic r_new_best;

  assign w_all9 = &w_is9;
  assign w_hold = w_all9 & LP_SAT;
  assign w_step = inc & ~clear & ~w_hold;
  assign w_gt   = |w_win;
  assign w_dash = ~show_best & (r_state == Idle);

  assign at_max   = w_all9;
  assign wrapped  = r_wrapped;
  assign new_best = r_new_best;

  // Per-digit carry, magnitude compare and display path.
  for (genvar gi = 0; gi < ND; gi++) begin : g_dig
    localparam logic [ND-1:0] LO = ND'((1 << gi) - 1);
    localparam logic [ND-1:0] HI = ND'(~((2 << gi) - 1));
    localparam logic [ND-1:0] UP = ND'(~((1 << gi) - 1));

    assign w_is9[gi]   = (r_cur[gi] == BCD_NINE);
    assign w_carry[gi] = &(w_is9 | ~LO);
    assign w_nxt[gi]   = w_carry[gi] ? bcd_inc(r_cur[gi])
                                     : r_cur[gi];

    assign w_eq[gi]  = (r_cur[gi] == r_best[gi]);
    assign w_win[gi] = (r_cur[gi] > r_best[gi])
                     & (&(w_eq | ~HI));

    assign w_sel[gi] = show_best ? r_best[gi] : r_cur[gi];
    assign w_nz[gi]  = (w_sel[gi] != 4'd0);

    if (gi == 0) begin : g_lsd
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = LP_BLANK & ~(|(w_nz & UP));
    end

    seg7_decode u_seg (
      .i_digit (w_sel[gi]),
      .o_seg   (w_glyph[gi])
    );

    assign HEX[gi] = w_dash      ? SEG_DASH  :
                     w_blank[gi] ? SEG_BLANK :
                                   w_glyph[gi];
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= Idle;
    else       r_state <= w_state_nxt;
  end

  // Next state: inc starts a game, clear ends it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      Idle:    if (inc && !clear) w_state_nxt = Count;
      Count:   if (clear)         w_state_nxt = Idle;
      default: w_state_nxt = Idle;
    endcase
  end

  // Current score: clear zeroes, inc advances unless held.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < ND; i++) begin
      if (Reset || clear) r_cur[i] <= 4'd0;
      else if (w_step)    r_cur[i] <= w_nxt[i];
    end
  end

  // Best score: committed on clear when beaten.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < ND; i++) begin
      if (Reset)              r_best[i] <= 4'd0;
      else if (clear && w_gt) r_best[i] <= r_cur[i];
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wrapped  <= 1'b0;
      r_new_best <= 1'b0;
    end else begin
      r_wrapped  <= w_step & w_all9;
      r_new_best <= clear & w_gt;
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: three parameter variants, one stimulus.
// Integer score model checked every cycle plus literal spot checks.
module tb_bcd_score_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inc = 1'b0;
  logic clr = 1'b0;
  logic sb  = 1'b0;

  logic [1:0][6:0] hex_o [3];
  logic [2:0]      am_o;
  logic [2:0]      wr_o;
  logic [2:0]      nb_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  localparam bit SAT [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit BLK [3] = '{1'b0, 1'b0, 1'b1};

  localparam logic [6:0] GL [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  int m_cur  [3];
  int m_best [3];
  bit m_cnt  [3];
  bit m_wr   [3];
  bit m_nb   [3];

  always #5 clk = ~clk;

  bcd_score_counter #(
    .NUM_DIGITS (2), .SATURATE (1), .BLANK_LZ (0)
  ) u_sat (
    .Clock (clk), .Reset (rst), .inc (inc),
    .clear (clr), .show_best (sb), .HEX (hex_o[0]),
    .at_max (am_o[0]), .wrapped (wr_o[0]),
    .new_best (nb_o[0])
  );

  bcd_score_counter #(
    .NUM_DIGITS (2), .SATURATE (0), .BLANK_LZ (0)
  ) u_wrap (
    .Clock (clk), .Reset (rst), .inc (inc),
    .clear (clr), .show_best (sb), .HEX (hex_o[1]),
    .at_max (am_o[1]), .wrapped (wr_o[1]),
    .new_best (nb_o[1])
  );

  bcd_score_counter #(
    .NUM_DIGITS (2), .SATURATE (1), .BLANK_LZ (1)
  ) u_blank (
    .Clock (clk), .Reset (rst), .inc (inc),
    .clear (clr), .show_best (sb), .HEX (hex_o[2]),
    .at_max (am_o[2]), .wrapped (wr_o[2]),
    .new_best (nb_o[2])
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] exp_hex(input int val,
                                          input bit show,
                                          input bit cnt,
                                          input bit blk);
    logic [13:0] r;
    logic [6:0]  g;
    int d;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? (val % 10) : ((val / 10) % 10);
      if (!show && !cnt)              g = 7'h3F;
      else if (blk && i > 0 && val < 10) g = 7'h7F;
      else                            g = GL[d];
      r[i*7 +: 7] = g;
    end
    return r;
  endfunction

  // Reference model: plain integer score arithmetic.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cur[k] = 0; m_best[k] = 0; m_cnt[k] = 0;
        m_wr[k] = 0;  m_nb[k] = 0;
      end else begin
        m_wr[k] = 0;
        m_nb[k] = 0;
        if (clr) begin
          if (m_cur[k] > m_best[k]) begin
            m_best[k] = m_cur[k];
            m_nb[k] = 1;
          end
          m_cur[k] = 0;
          m_cnt[k] = 0;
        end else if (inc) begin
          m_cnt[k] = 1;
          if (m_cur[k] == 99) begin
            if (!SAT[k]) begin
              m_cur[k] = 0;
              m_wr[k] = 1;
            end
          end else begin
            m_cur[k] = m_cur[k] + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("hex%0d", k), 32'(hex_o[k]),
              32'(exp_hex(sb ? m_best[k] : m_cur[k],
                          sb, m_cnt[k], BLK[k])));
        check($sformatf("at_max%0d", k), 32'(am_o[k]),
              32'(m_cur[k] == 99));
        check($sformatf("wrapped%0d", k), 32'(wr_o[k]),
              32'(m_wr[k]));
        check($sformatf("new_best%0d", k), 32'(nb_o[k]),
              32'(m_nb[k]));
      end
    end
  end

  task automatic cyc(input bit i, input bit c, input bit s);
    inc = i;
    clr = c;
    sb  = s;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, sb);
    cyc(0, 0, sb);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_hex", 32'(hex_o[0]), 32'({7'h3F, 7'h3F}));
    check("rst_max", 32'(am_o[0]), 32'd0);

    cyc(1, 0, 0);
    check("one_inc", 32'(hex_o[0]), 32'({7'h40, 7'h79}));
    repeat (8) cyc(1, 0, 0);
    check("score09", 32'(hex_o[0]), 32'({7'h40, 7'h10}));
    cyc(1, 0, 0);
    check("score10", 32'(hex_o[0]), 32'({7'h79, 7'h40}));
    repeat (89) cyc(1, 0, 0);
    check("max_sat", 32'(am_o[0]), 32'd1);
    check("max_wrap", 32'(am_o[1]), 32'd1);
    check("score99", 32'(hex_o[0]), 32'({7'h10, 7'h10}));

    cyc(1, 0, 0);
    check("sat_hold", 32'(hex_o[0]), 32'({7'h10, 7'h10}));
    check("sat_nowrap", 32'(wr_o[0]), 32'd0);
    check("wrap_zero", 32'(hex_o[1]), 32'({7'h40, 7'h40}));
    check("wrap_pulse", 32'(wr_o[1]), 32'd1);
    cyc(0, 0, 0);
    check("wrap_drop", 32'(wr_o[1]), 32'd0);

    do_reset();
    cyc(0, 0, 1);
    check("rst_best", 32'(hex_o[0]), 32'({7'h40, 7'h40}));

    repeat (37) cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("nb37", 32'(nb_o[0]), 32'd1);
    cyc(0, 0, 1);
    check("best37", 32'(hex_o[0]), 32'({7'h30, 7'h78}));
    check("nb_drop", 32'(nb_o[0]), 32'd0);
    cyc(0, 0, 0);
    check("idle_dash", 32'(hex_o[0]), 32'({7'h3F, 7'h3F}));

    repeat (12) cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("nb12", 32'(nb_o[0]), 32'd0);
    cyc(0, 0, 1);
    check("keep37", 32'(hex_o[0]), 32'({7'h30, 7'h78}));
    cyc(0, 1, 0);
    check("idle_clr", 32'(nb_o[0]), 32'd0);

    do_reset();
    repeat (5) cyc(1, 0, 0);
    check("blank05", 32'(hex_o[2]), 32'({7'h7F, 7'h12}));
    check("plain05", 32'(hex_o[0]), 32'({7'h40, 7'h12}));
    cyc(1, 1, 0);
    check("clr_win", 32'(hex_o[0]), 32'({7'h3F, 7'h3F}));
    cyc(0, 0, 1);
    check("best05", 32'(hex_o[0]), 32'({7'h40, 7'h12}));
    check("bbest05", 32'(hex_o[2]), 32'({7'h7F, 7'h12}));
    do_reset();
    check("best_rst", 32'(hex_o[0]), 32'({7'h40, 7'h40}));
    check("bbest_rst", 32'(hex_o[2]), 32'({7'h7F, 7'h40}));

    cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
